// File: rtl/input_debounce_conditioner_if.sv
// Pin-side and PIO-side signals of the input debounce conditioner.
// The conditioner connects through the master modport: it samples the raw
// pins and drives the clean levels and event pulses. Whatever sits on the
// other side (board pins plus the PIO inputs, or a bench) uses the slave
// modport.
//
// Signalling: there is no handshake. The raw pins are asynchronous levels.
// Every output is registered. Each pulse output is high for exactly one
// clk_clk cycle per accepted transition, and no consumer can stall it.
interface input_debounce_conditioner_if #(
    parameter int N_BTN = 4,
    parameter int N_SW  = 10
) ();
    logic [N_BTN-1:0] key_raw_n;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] button_clean_n;
    logic [N_SW-1:0]  switch_clean;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_SW-1:0]  sw_change;
    logic             any_event;

    modport master (
        input  key_raw_n,
        input  sw_raw,
        output button_clean_n,
        output switch_clean,
        output btn_press,
        output btn_release,
        output sw_change,
        output any_event
    );

    modport slave (
        output key_raw_n,
        output sw_raw,
        input  button_clean_n,
        input  switch_clean,
        input  btn_press,
        input  btn_release,
        input  sw_change,
        input  any_event
    );
endinterface

// File: rtl/input_debounce_conditioner.sv
// Debounce conditioner for the DE10-Lite KEY and SW pins.
// Each bit goes through the same three stages:
//   - a 2-flop synchronizer
//   - an integrating counter that accepts a new level only after
//     DEBOUNCE_CYCLES consecutive cycles that disagree with the clean level
//   - registered single-cycle edge pulses
// Buttons and switches are handled as one concatenated vector. Buttons sit
// in the low bits and switches in the high bits. Only the reset value
// differs: buttons reset to 1 (released) and switches reset to 0.
// DEBOUNCE_CYCLES must be >= 1, and 2^CNT_W must be >= DEBOUNCE_CYCLES.
module input_debounce_conditioner #(
    parameter int N_BTN           = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input_debounce_conditioner_if.master io
);

    localparam int N = N_BTN + N_SW;
    localparam logic [N-1:0]     RST_VAL = {{N_SW{1'b0}}, {N_BTN{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     raw;
    logic [N-1:0]     meta;
    logic [N-1:0]     sync;
    logic [N-1:0]     clean;
    logic [N-1:0]     clean_next;
    logic [N-1:0]     accept;
    logic [CNT_W-1:0] cnt      [N];
    logic [CNT_W-1:0] cnt_next [N];

    logic [N_BTN-1:0] press_next;
    logic [N_BTN-1:0] release_next;
    logic [N_SW-1:0]  change_next;
    logic             event_next;

    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic [N_SW-1:0]  change_q;
    logic             event_q;

    assign raw = {io.sw_raw, io.key_raw_n};

    // Two-stage synchronizer. Raw pins are only ever seen by the first stage.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Integration.
    // A bit whose synchronized value agrees with its clean level holds its
    // counter at zero, so any bounce back restarts integration.
    // A bit that disagrees counts up. On the cycle it has already disagreed
    // for DEBOUNCE_CYCLES-1 cycles, this disagreement is the DEBOUNCE_CYCLES-th
    // one, so the bit is accepted and its counter returns to zero.
    // The counter therefore never exceeds CNT_MAX and never wraps.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = '0;
            if (sync[i] != clean[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        clean_next = clean ^ accept;
    end

    // Clean levels and per-bit counters.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            clean <= RST_VAL;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            clean <= clean_next;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Edge classification.
    // The direction comes from the clean level before the flip:
    // a button that was 1 (released) and is accepted is a press.
    always_comb begin
        press_next   = accept[N_BTN-1:0] & clean[N_BTN-1:0];
        release_next = accept[N_BTN-1:0] & ~clean[N_BTN-1:0];
        change_next  = accept[N-1:N_BTN];
        event_next   = |accept;
    end

    // Pulse registers.
    // They load on the same edge as clean, so each pulse is high during the
    // first cycle of the new clean level.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            press_q   <= '0;
            release_q <= '0;
            change_q  <= '0;
            event_q   <= 1'b0;
        end else begin
            press_q   <= press_next;
            release_q <= release_next;
            change_q  <= change_next;
            event_q   <= event_next;
        end
    end

    assign io.button_clean_n = clean[N_BTN-1:0];
    assign io.switch_clean   = clean[N-1:N_BTN];
    assign io.btn_press      = press_q;
    assign io.btn_release    = release_q;
    assign io.sw_change      = change_q;
    assign io.any_event      = event_q;

endmodule
